// File: rtl/ysyx_220053_ifu_fetch_if.sv
// ysyx_220053_ifu_fetch_if: imem request/response plus decode/execute handshake bundle.
// master = fetch unit side, slave = memory/decode/execute side.
interface ysyx_220053_ifu_fetch_if #(parameter int XLEN = 64);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            imem_err;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] pc;
  logic            dnpc_valid;
  logic [XLEN-1:0] dnpc;
  logic            halt;
  modport master (
    output imem_req, imem_addr, inst_valid, inst, pc,
    input  imem_ready, imem_rvalid, imem_rdata, imem_err, inst_ready, dnpc_valid, dnpc, halt
  );
  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, pc,
    output imem_ready, imem_rvalid, imem_rdata, imem_err, inst_ready, dnpc_valid, dnpc, halt
  );
endinterface

// File: rtl/ysyx_220053_ifu_fetch.sv
// ysyx_220053_ifu_fetch: single-outstanding instruction fetch FSM owning the PC.
// Optional IFU_PERF_CNT_EN adds fetch_cnt/stall_cnt performance counters.
module ysyx_220053_ifu_fetch #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  ysyx_220053_ifu_fetch_if.master    bus,
  output logic                       halted,
  output logic                       fault,
  output logic [1:0]                 fault_cause
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [63:0]                fetch_cnt,
  output logic [63:0]                stall_cnt
`endif
);
  typedef enum logic [2:0] {S_REQ, S_WAIT, S_ISSUE, S_NEXT, S_HALT, S_FAULT} state_t;
  state_t          state, state_nxt;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     inst_q;
  logic            rsp_ok, rsp_err, take_dnpc, misaligned;
  assign rsp_ok     = state == S_WAIT && bus.imem_rvalid && !bus.imem_err;
  assign rsp_err    = state == S_WAIT && bus.imem_rvalid && bus.imem_err;
  // a zero-wait execute returns dnpc in the same cycle decode accepts the inst
  assign take_dnpc  = bus.dnpc_valid && (state == S_NEXT || (state == S_ISSUE && bus.inst_ready));
  assign misaligned = bus.dnpc[1:0] != 2'b00;
  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ:   state_nxt = bus.imem_ready ? S_WAIT : S_REQ;
      S_WAIT:  state_nxt = bus.imem_rvalid ? (bus.imem_err ? S_FAULT : S_ISSUE) : S_WAIT;
      S_ISSUE: state_nxt = bus.inst_ready ? S_NEXT : S_ISSUE;
      default: state_nxt = state;
    endcase
    if (take_dnpc) state_nxt = bus.halt ? S_HALT : (misaligned ? S_FAULT : S_REQ);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_REQ;
      pc_q        <= RESET_PC;
      inst_q      <= '0;
      fault_cause <= 2'b00;
    end else begin
      state <= state_nxt;
      if (rsp_ok) inst_q <= bus.imem_rdata;
      if (take_dnpc && !bus.halt) pc_q <= bus.dnpc;
      if (rsp_err) fault_cause <= 2'b01;
      else if (take_dnpc && !bus.halt && misaligned) fault_cause <= 2'b10;
    end
  end
  assign bus.imem_req   = state == S_REQ;
  assign bus.imem_addr  = pc_q;
  assign bus.inst_valid = state == S_ISSUE;
  assign bus.inst       = inst_q;
  assign bus.pc         = pc_q;
  assign halted         = state == S_HALT;
  assign fault          = state == S_FAULT;
`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (rsp_ok) fetch_cnt <= fetch_cnt + 64'd1;
      if ((state == S_REQ && !bus.imem_ready) || (state == S_WAIT && !bus.imem_rvalid)) stall_cnt <= stall_cnt + 64'd1;
    end
  end
`endif
endmodule

// File: tb/tb_ysyx_220053_ifu_fetch.sv
// tb_ysyx_220053_ifu_fetch: directed self-checking bench for the fetch FSM.
module tb_ysyx_220053_ifu_fetch;
  logic clk, rst;
  logic halted, fault;
  logic [1:0] fault_cause;
  int total = 0;
  int bad = 0;
  ysyx_220053_ifu_fetch_if #(.XLEN(64)) bus();
`ifdef IFU_PERF_CNT_EN
  logic [63:0] fetch_cnt, stall_cnt;
`endif
  ysyx_220053_ifu_fetch dut (
    .clk(clk), .rst(rst), .bus(bus),
    .halted(halted), .fault(fault), .fault_cause(fault_cause)
`ifdef IFU_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
`endif
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic fetch(input logic [63:0] addr, input logic [31:0] data);
    chk("req_hi", bus.imem_req, 1);
    chk("req_addr", bus.imem_addr, addr);
    bus.imem_ready = 1;
    step();
    bus.imem_ready = 0;
    chk("wait_req_lo", bus.imem_req, 0);
    bus.imem_rvalid = 1;
    bus.imem_rdata = data;
    step();
    bus.imem_rvalid = 0;
    chk("iv_hi", bus.inst_valid, 1);
    chk("inst", bus.inst, data);
    chk("pc", bus.pc, addr);
  endtask
  task automatic retire(input logic [63:0] nxt);
    bus.inst_ready = 1;
    bus.dnpc_valid = 1;
    bus.dnpc = nxt;
    step();
    bus.inst_ready = 0;
    bus.dnpc_valid = 0;
  endtask
  task automatic do_reset();
    rst = 0;
    step();
    rst = 1;
  endtask
  initial begin
    rst = 0;
    bus.imem_ready = 0; bus.imem_rvalid = 0; bus.imem_rdata = 0; bus.imem_err = 0;
    bus.inst_ready = 0; bus.dnpc_valid = 0; bus.dnpc = 0; bus.halt = 0;
    step(); step();
    chk("rst_pc", bus.pc, 64'h8000_0000);
    chk("rst_iv", bus.inst_valid, 0);
    chk("rst_inst", bus.inst, 0);
    chk("rst_halted", halted, 0);
    chk("rst_fault", fault, 0);
    chk("rst_cause", fault_cause, 0);
    rst = 1;
    fetch(64'h8000_0000, 32'h0000_0413);
    for (int i = 0; i < 3; i++) begin
      retire(64'h8000_0004 + 64'(4 * i));
      fetch(64'h8000_0004 + 64'(4 * i), 32'h0010_0093 + 32'(i));
    end
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_iv", bus.inst_valid, 1);
      chk("bp_inst", bus.inst, 32'h0010_0095);
      chk("bp_pc", bus.pc, 64'h8000_000C);
      chk("bp_req", bus.imem_req, 0);
    end
    bus.inst_ready = 1;
    step();
    bus.inst_ready = 0;
    chk("next_iv", bus.inst_valid, 0);
    step();
    chk("next_req", bus.imem_req, 0);
    bus.dnpc_valid = 1;
    bus.dnpc = 64'h8000_1000;
    step();
    bus.dnpc_valid = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("nr_req", bus.imem_req, 1);
      chk("nr_addr", bus.imem_addr, 64'h8000_1000);
    end
    fetch(64'h8000_1000, 32'h0010_0073);
    bus.halt = 1;
    retire(64'h8000_1004);
    bus.halt = 0;
    bus.imem_ready = 1;
    chk("halted", halted, 1);
    chk("halt_pc", bus.pc, 64'h8000_1000);
    for (int i = 0; i < 3; i++) begin
      bus.dnpc_valid = 1;
      step();
      chk("halt_req", bus.imem_req, 0);
      chk("halt_sticky", halted, 1);
    end
    bus.dnpc_valid = 0;
    bus.imem_ready = 0;
    do_reset();
    chk("rst2_halted", halted, 0);
    bus.imem_ready = 1;
    step();
    bus.imem_ready = 0;
    bus.imem_rvalid = 1;
    bus.imem_err = 1;
    step();
    bus.imem_rvalid = 0;
    bus.imem_err = 0;
    chk("berr_fault", fault, 1);
    chk("berr_cause", fault_cause, 2'b01);
    chk("berr_iv", bus.inst_valid, 0);
    step();
    chk("berr_req", bus.imem_req, 0);
    do_reset();
    chk("rst3_fault", fault, 0);
    fetch(64'h8000_0000, 32'h0000_0013);
    retire(64'h8000_0006);
    chk("mis_fault", fault, 1);
    chk("mis_cause", fault_cause, 2'b10);
    chk("mis_pc", bus.pc, 64'h8000_0006);
    chk("mis_req", bus.imem_req, 0);
    do_reset();
    bus.imem_ready = 1;
    step();
    bus.imem_ready = 0;
    chk("aw_req", bus.imem_req, 0);
    rst = 0;
    #2;
    chk("arst_pc", bus.pc, 64'h8000_0000);
    chk("arst_req", bus.imem_req, 1);
    chk("arst_fault", fault, 0);
`ifdef IFU_PERF_CNT_EN
    chk("arst_fcnt", fetch_cnt, 0);
    chk("arst_scnt", stall_cnt, 0);
`endif
    step();
    rst = 1;
    bus.imem_rvalid = 1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    step();
    bus.imem_rvalid = 0;
    chk("stale_iv", bus.inst_valid, 0);
    fetch(64'h8000_0000, 32'h0000_0013);
    retire(64'h8000_0004);
    fetch(64'h8000_0004, 32'h0000_0113);
    retire(64'hFFFF_FFFF_FFFF_FFFC);
    fetch(64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_0213);
`ifdef IFU_PERF_CNT_EN
    chk("fetch_cnt", fetch_cnt, 3);
    chk("stall_cnt", stall_cnt, 1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
